// File: rtl/trap_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_sequencer: preemption timer with trap entry/return sequencing.     |
// | Optional lost-tick counter: define TRAP_TICK_OVERRUN_EN.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module trap_sequencer #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     CNT_W       = 16,
  parameter int unsigned     QUANTUM     = 1000,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timerEnable,
  input  logic             quantumLoad,
  input  logic [CNT_W-1:0] quantumValue,
  input  logic             mieWrite,
  input  logic             mieValue,
  input  logic             instrRetire,
  input  logic             isMret,
  input  logic [XLEN-1:0]  nextPc,
  output logic             takeTrap,
  output logic             returnTaken,
  output logic [XLEN-1:0]  trapVector,
  output logic [XLEN-1:0]  mepc,
  output logic             mie,
  output logic             interruptPending,
  output logic             inHandler,
  output logic [7:0]       overrunCount
);

  localparam logic [CNT_W-1:0] C_QREG_RST = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] C_CNT_RST  = CNT_W'((QUANTUM == 0) ? 0 : QUANTUM - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_RETURN  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_qreg;
  logic             r_pending;
  logic             r_mie;
  logic             r_mpie;
  logic [XLEN-1:0]  r_mepc;
  logic             r_take;
  logic             r_return;
  logic             r_in_handler;
  logic             w_tick;
  logic             w_accept;
  logic             w_mret;

  // A zero quantum is treated as one: reload to zero so every enabled cycle ticks.
  function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] q);
    return (q == '0) ? '0 : q - 1'b1;
  endfunction

  assign w_tick   = timerEnable && !quantumLoad && (r_count == '0);
  assign w_accept = (r_state == ST_RUN) && r_pending && r_mie && instrRetire && !isMret;
  assign w_mret   = (r_state == ST_HANDLER) && instrRetire && isMret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= C_CNT_RST;
      r_qreg  <= C_QREG_RST;
    end else if (quantumLoad) begin
      r_qreg  <= quantumValue;
      r_count <= reload_of(quantumValue);
    end else if (timerEnable) begin
      r_count <= (r_count == '0) ? reload_of(r_qreg) : r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_pending    <= 1'b0;
      r_mie        <= 1'b0;
      r_mpie       <= 1'b0;
      r_mepc       <= '0;
      r_take       <= 1'b0;
      r_return     <= 1'b0;
      r_in_handler <= 1'b0;
    end else begin
      // A tick landing on the acceptance edge must survive as a new pending request.
      if (w_tick)        r_pending <= 1'b1;
      else if (w_accept) r_pending <= 1'b0;

      if (w_accept)      r_mie <= 1'b0;
      else if (w_mret)   r_mie <= r_mpie;
      else if (mieWrite) r_mie <= mieValue;

      r_take   <= 1'b0;
      r_return <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_mepc       <= nextPc;
            r_mpie       <= r_mie;
            r_state      <= ST_ENTRY;
            r_take       <= 1'b1;
            r_in_handler <= 1'b1;
          end
        end
        ST_ENTRY: begin
          r_state <= ST_HANDLER;
        end
        ST_HANDLER: begin
          if (w_mret) begin
            r_state      <= ST_RETURN;
            r_return     <= 1'b1;
            r_in_handler <= 1'b0;
          end
        end
        ST_RETURN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef TRAP_TICK_OVERRUN_EN
  logic [7:0] r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 8'd0;
    end else if (w_tick && r_pending && !w_accept && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  assign overrunCount = r_overrun;
`else
  assign overrunCount = 8'd0;
`endif

  assign takeTrap         = r_take;
  assign returnTaken      = r_return;
  assign trapVector       = TRAP_VECTOR;
  assign mepc             = r_mepc;
  assign mie              = r_mie;
  assign interruptPending = r_pending;
  assign inHandler        = r_in_handler;

endmodule
`default_nettype wire

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Preemption timer plus trap entry/return sequencer for the single-cycle core.
- Generates periodic timer ticks and latches them as a pending interrupt.
- Takes the interrupt only at an instruction boundary; saves the return PC (MEPC) and steers the PC mux to the trap vector, or back to MEPC on MRET.
- Replaces the controller's raw timerInterrupt hijack with a registered, maskable, non-nesting sequence.

Parameters:
- XLEN, 32, PC/MEPC width.
- CNT_W, 16, quantum counter width.
- QUANTUM, 1000, reset value of the quantum register, in cycles per tick.
- TRAP_VECTOR, 32'h0000_0010, handler entry address.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- timerEnable  in  1  quantum counter decrements only when high
- quantumLoad  in  1  load quantumValue into the quantum register and restart the counter
- quantumValue  in  CNT_W  new quantum
- mieWrite  in  1  write the global interrupt enable
- mieValue  in  1  value for mieWrite
- instrRetire  in  1  the current instruction completes this cycle
- isMret  in  1  the retiring instruction is MRET
- nextPc  in  XLEN  PC of the instruction after the retiring one
- takeTrap  out  1  PC mux select: trapVector; drives csrWriteEnable/isTrap
- returnTaken  out  1  PC mux select: mepc
- trapVector  out  XLEN  constant TRAP_VECTOR
- mepc  out  XLEN  saved return PC
- mie  out  1  global interrupt enable
- interruptPending  out  1  tick latched, not yet serviced
- inHandler  out  1  state is ENTRY or HANDLER
- overrunCount  out  8  lost-tick counter (see Optional Feature)

Behaviour:
- Reset values (async on rst_n low):
  - state=RUN; counter=QUANTUM-1; quantum register=QUANTUM.
  - interruptPending=0, mie=0, mpie=0, mepc=0.
  - takeTrap=0, returnTaken=0, overrunCount=0.
- Quantum counter:
  - If quantumLoad: qreg<=quantumValue and counter<=max(quantumValue,1)-1. quantumLoad has priority over decrement; no tick is generated that cycle.
  - Else if timerEnable and counter==0: tick=1 and counter<=max(qreg,1)-1.
  - Else if timerEnable: counter<=counter-1.
  - Otherwise hold.
  - quantumValue=0 behaves as 1, giving a tick every enabled cycle.
- Pending:
  - Set on tick; cleared on trap acceptance.
  - A tick in the acceptance cycle leaves pending=1, so the new tick is kept.
- FSM states: RUN, ENTRY, HANDLER, RETURN. takeTrap and returnTaken are Moore outputs.
- RUN:
  - Accept a trap when interruptPending & mie & instrRetire & !isMret.
  - On acceptance, at that edge: mepc<=nextPc, mpie<=mie, mie<=0, pending cleared, state<=ENTRY.
  - An MRET retiring in RUN is ignored; no state change.
- ENTRY:
  - takeTrap=1 for exactly one cycle, state<=HANDLER.
  - instrRetire and isMret are ignored in this state (core flushing).
- HANDLER:
  - No nesting: ticks still set pending, but no acceptance.
  - On instrRetire & isMret: mie<=mpie, state<=RETURN.
- RETURN:
  - returnTaken=1 for exactly one cycle, state<=RUN.
  - No trap acceptance in this cycle.
- mieWrite:
  - Applies in any state, except that it is dropped in the acceptance cycle (mie<=0 wins) and in the MRET cycle (mpie restore wins).
- Latency: takeTrap rises 1 cycle after the acceptance edge. The first handler instruction executes 2 cycles after the retiring instruction.
- Reset mid-handler: returns to RUN with mie=0; MEPC is lost.
- trapVector is constant; mepc is stable outside acceptance edges.

Optional Feature:
- Macro TRAP_TICK_OVERRUN_EN.
- Defined: overrunCount increments (saturating at 255) on each tick that arrives while interruptPending is already 1 and no acceptance occurs that cycle. Cleared only by reset.
- Undefined: overrunCount is tied to 0 and no counter logic is generated.

Test Plan:
- Tick cadence: quantumLoad with quantumValue=5, timerEnable=1, mie=0 → first tick 5 cycles after the load, then interruptPending=1; mepc remains 0.
- Trap entry: mie=1, pending=1, instrRetire=1, nextPc=0x40 → next cycle takeTrap=1 for 1 cycle, mepc=0x40, mie=0, inHandler=1, pending=0.
- Trap return: in HANDLER with isMret=1 and instrRetire=1 → next cycle returnTaken=1 for 1 cycle, mie=1, state RUN; a trap pending at that point is taken no earlier than the next retiring instruction.
- Quantum 0 and nesting: quantumValue=0 → a tick every enabled cycle. While in HANDLER, pending=1 but takeTrap stays 0. With TRAP_TICK_OVERRUN_EN defined, overrunCount increments each cycle and saturates at 255.
- Mid-handler reset: rst_n low for 1 cycle while in HANDLER → immediately takeTrap=0, mie=0, mepc=0, counter=QUANTUM-1, inHandler=0.
- Acceptance-cycle conflicts: acceptance with simultaneous mieWrite=1/mieValue=1 and a tick → mie=0 after the edge and interruptPending=1 after the edge.
